// File: rtl/mc_mips_core.sv
// mc_mips_core: multi-cycle MIPS subset core with one shared memory port.
// Supports lw, sw, R-type add/sub/and/or/slt, addi, beq and j; anything else halts.
// Optional macro INSTRET_CNT_EN adds a 32-bit retired-instruction counter port.
module mc_mips_core #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            CLK,
    input  logic            rst,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic [XLEN-1:0] pc,
    output logic            instr_done,
    output logic            halted
`ifdef INSTRET_CNT_EN
    ,
    output logic [31:0]     instret
`endif
);

    localparam int unsigned NREG = 32;

    typedef enum logic [3:0] {
        BOOT, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, HALT
    } state_t;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] mdr_q, mdr_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] alu_out_q, alu_out_d;
    logic [XLEN-1:0] rf_q [NREG];

    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;

    logic [XLEN-1:0] alu_a, alu_b, alu_y;
    alu_op_t         alu_op;

    logic [5:0]      opcode, funct;
    logic [4:0]      rs, rt, rd;
    logic [XLEN-1:0] imm_ext;

    assign opcode  = ir_q[31:26];
    assign rs      = ir_q[25:21];
    assign rt      = ir_q[20:16];
    assign rd      = ir_q[15:11];
    assign funct   = ir_q[5:0];
    assign imm_ext = {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};
    assign pc      = pc_q;

    // ALU operand/opcode selection by state: PC+4, branch target, address, execute, compare
    always_comb begin
        alu_a  = pc_q;
        alu_b  = XLEN'(4);
        alu_op = ALU_ADD;
        case (state_q)
            DECODE: alu_b = imm_ext << 2;
            MEMADR, ADDIEX: begin
                alu_a = a_q;
                alu_b = imm_ext;
            end
            EXEC: begin
                alu_a = a_q;
                alu_b = b_q;
                case (funct)
                    6'h22:   alu_op = ALU_SUB;
                    6'h24:   alu_op = ALU_AND;
                    6'h25:   alu_op = ALU_OR;
                    6'h2A:   alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
            end
            BRANCH: begin
                alu_a  = a_q;
                alu_b  = b_q;
                alu_op = ALU_SUB;
            end
            default: ;
        endcase
    end

    // Shared ALU; arithmetic wraps modulo 2^XLEN
    always_comb begin
        case (alu_op)
            ALU_SUB: alu_y = alu_a - alu_b;
            ALU_AND: alu_y = alu_a & alu_b;
            ALU_OR:  alu_y = alu_a | alu_b;
            ALU_SLT: alu_y = {{(XLEN-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            default: alu_y = alu_a + alu_b;
        endcase
    end

    // Controller: next state, datapath register updates and memory-port drive
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        mdr_d      = mdr_q;
        a_d        = a_q;
        b_d        = b_q;
        alu_out_d  = alu_out_q;
        rf_we      = 1'b0;
        rf_waddr   = rt;
        rf_wdata   = alu_out_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = pc_q;
        mem_wdata  = b_q;
        instr_done = 1'b0;
        halted     = 1'b0;
        case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_d    = mem_rdata[31:0];
                    pc_d    = alu_y;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                a_d       = rf_q[rs];
                b_d       = rf_q[rt];
                alu_out_d = alu_y;
                case (opcode)
                    6'h23, 6'h2B: state_d = MEMADR;
                    6'h00:        state_d = EXEC;
                    6'h08:        state_d = ADDIEX;
                    6'h04:        state_d = BRANCH;
                    6'h02:        state_d = JUMP;
                    default:      state_d = HALT;
                endcase
            end
            MEMADR: begin
                alu_out_d = alu_y;
                state_d   = (opcode == 6'h2B) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                mem_req  = 1'b1;
                mem_addr = alu_out_q;
                if (mem_ready) begin
                    mdr_d   = mem_rdata;
                    state_d = MEMWB;
                end
            end
            MEMWB: begin
                rf_we      = 1'b1;
                rf_wdata   = mdr_q;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = alu_out_q;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
            end
            EXEC: begin
                case (funct)
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: begin
                        alu_out_d = alu_y;
                        state_d   = ALUWB;
                    end
                    default: state_d = HALT;
                endcase
            end
            ALUWB: begin
                rf_we      = 1'b1;
                rf_waddr   = rd;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            ADDIEX: begin
                alu_out_d = alu_y;
                state_d   = ADDIWB;
            end
            ADDIWB: begin
                rf_we      = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            BRANCH: begin
                if (alu_y == '0) pc_d = alu_out_q;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            JUMP: begin
                pc_d       = {pc_q[XLEN-1:28], ir_q[25:0], 2'b00};
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            HALT: halted = 1'b1;
            default: state_d = HALT;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            mdr_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mdr_q     <= mdr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
        end
    end

    // Register file; r0 is never written so it always reads zero
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (rf_we && (rf_waddr != 5'd0)) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end

`ifdef INSTRET_CNT_EN
    logic [31:0] instret_q;

    // Retired-instruction counter, wraps at 2^32
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) instret_q <= '0;
        else if (instr_done) instret_q <= instret_q + 32'd1;
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_mc_mips_core.sv
// Directed bench for mc_mips_core: ALU vector table plus hand-written multi-cycle sequences.
module tb_mc_mips_core;

    logic        CLK = 1'b0;
    logic        rst;
    logic        mem_req, mem_we, mem_ready, instr_done, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
`ifdef INSTRET_CNT_EN
    logic [31:0] instret;
`endif

    mc_mips_core #(.XLEN(32), .RESET_PC(32'h100)) dut (
        .CLK(CLK), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc(pc), .instr_done(instr_done), .halted(halted)
`ifdef INSTRET_CNT_EN
        , .instret(instret)
`endif
    );

    always #5 CLK = ~CLK;

    // Memory model: code at >=0x100 is zero-wait; data below 0x100 gets wait_n wait cycles
    logic [31:0] mem [256];
    int          wait_n;
    bit          tie_high;
    int          cnt;

    assign mem_rdata = mem[mem_addr[9:2]];
    assign mem_ready = tie_high ? 1'b1 : (mem_req && (mem_addr >= 32'h100 || cnt >= wait_n));

    always @(posedge CLK) cnt <= (mem_req && !mem_ready) ? cnt + 1 : 0;

    int          errors = 0, checks = 0, cyc = 0, nwait = 0;
    bit          prev_wait, last_done, halt_watch;
    logic [31:0] p_addr, p_wdata;
    logic        p_we;
    int          done_cyc[$];
    logic [31:0] done_pc[$], wr_addr[$], wr_data[$];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [5:0]  funct;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] j_type(input logic [25:0] t);
        return {6'h02, t};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    endtask

    // Program words placed from the reset vector 0x100 onward
    task automatic put(input int idx, input logic [31:0] w);
        mem[64 + idx] = w;
    endtask

    // One clock: sample at the falling edge, log writes/retirements, check port stability
    task automatic tick();
        @(negedge CLK);
        cyc++;
        if (last_done) done_pc.push_back(pc);
        last_done = instr_done;
        if (mem_req && prev_wait) begin
            chk("stable_addr", mem_addr, p_addr);
            chk("stable_we", 32'(mem_we), 32'(p_we));
            chk("stable_wdata", mem_wdata, p_wdata);
        end
        prev_wait = mem_req && !mem_ready;
        if (prev_wait) nwait++;
        p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata;
        if (mem_req && mem_we && mem_ready) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            mem[mem_addr[9:2]] = mem_wdata;
        end
        if (instr_done) done_cyc.push_back(cyc);
        if (halt_watch) begin
            chk("halt_noreq", 32'(mem_req), 32'd0);
            chk("halt_nodone", 32'(instr_done), 32'd0);
        end
    endtask

    // Hold reset two cycles, release at a falling edge; the following cycle is BOOT (cycle 1)
    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge CLK);
        done_cyc.delete(); done_pc.delete(); wr_addr.delete(); wr_data.delete();
        prev_wait = 0; last_done = 0; nwait = 0;
        rst = 1'b1;
        cyc = 1;
    endtask

    task automatic run_until_halt(input int max);
        int n = 0;
        while (!halted && n < max) begin
            tick();
            n++;
        end
        chk("halt_reached", 32'(halted), 32'd1);
    endtask

    task automatic run_until_done(input int want, input int max);
        int n = 0;
        while (done_pc.size() < want && n < max) begin
            tick();
            n++;
        end
        chk("done_count", 32'(done_pc.size() >= want), 32'd1);
    endtask

    initial begin
        rst = 1'b0; tie_high = 1'b1; wait_n = 0; halt_watch = 0;
        vecs[0] = '{16'd5,    16'd7,    6'h20, 32'd12};
        vecs[1] = '{16'd5,    16'd7,    6'h22, 32'hFFFF_FFFE};
        vecs[2] = '{16'hC,    16'hA,    6'h24, 32'h8};
        vecs[3] = '{16'hC,    16'hA,    6'h25, 32'hE};
        vecs[4] = '{16'hFFFF, 16'd5,    6'h2A, 32'd1};
        vecs[5] = '{16'd5,    16'hFFFF, 6'h2A, 32'd0};
        vecs[6] = '{16'h8000, 16'h8000, 6'h20, 32'hFFFF_0000};
        vecs[7] = '{16'd0,    16'd1,    6'h22, 32'hFFFF_FFFF};
        vecs[8] = '{16'h7FFF, 16'h7FFF, 6'h20, 32'h0000_FFFE};

        // ALU table: addi $1,a; addi $2,b; op $3,$1,$2; sw $3,0x80($0); halt
        foreach (vecs[i]) begin
            clear_mem();
            put(0, i_type(6'h08, 5'd0, 5'd1, vecs[i].a));
            put(1, i_type(6'h08, 5'd0, 5'd2, vecs[i].b));
            put(2, r_type(5'd1, 5'd2, 5'd3, vecs[i].funct));
            put(3, i_type(6'h2B, 5'd0, 5'd3, 16'h0080));
            put(4, 32'hFC00_0000);
            do_reset();
            if (i == 0) begin
                #1;
                chk("boot_req", 32'(mem_req), 32'd0);
                chk("boot_halted", 32'(halted), 32'd0);
                chk("boot_pc", pc, 32'h100);
                tick();
                chk("fetch_req", 32'(mem_req), 32'd1);
                chk("fetch_we", 32'(mem_we), 32'd0);
                chk("fetch_addr", mem_addr, 32'h100);
                tick();
                chk("pc_after_fetch", pc, 32'h104);
            end
            run_until_halt(200);
            chk("alu_wr_addr", wr_addr[0], 32'h80);
            chk("alu_wr_data", wr_data[0], vecs[i].exp);
            chk("alu_retired", 32'(done_cyc.size()), 32'd4);
            if (i == 0) begin
                chk("done_cycle0", 32'(done_cyc[0]), 32'd5);
                chk("done_cycle1", 32'(done_cyc[1]), 32'd9);
                chk("done_cycle2", 32'(done_cyc[2]), 32'd13);
            end
        end

        // sw/lw with two data wait cycles per access
        clear_mem();
        tie_high = 1'b0; wait_n = 2;
        put(0, i_type(6'h08, 5'd0, 5'd1, 16'd5));
        put(1, i_type(6'h08, 5'd0, 5'd2, 16'd7));
        put(2, r_type(5'd1, 5'd2, 5'd3, 6'h20));
        put(3, i_type(6'h2B, 5'd0, 5'd3, 16'h0008));
        put(4, i_type(6'h23, 5'd0, 5'd4, 16'h0008));
        put(5, i_type(6'h2B, 5'd0, 5'd4, 16'h0084));
        put(6, 32'hFC00_0000);
        do_reset();
        run_until_halt(300);
        chk("sw_addr", wr_addr[0], 32'h8);
        chk("sw_data", wr_data[0], 32'd12);
        chk("lw_store_addr", wr_addr[1], 32'h84);
        chk("lw_store_data", wr_data[1], 32'd12);
        chk("sw_latency", 32'(done_cyc[3] - done_cyc[2]), 32'd6);
        chk("lw_latency", 32'(done_cyc[4] - done_cyc[3]), 32'd7);
        chk("wait_cycles_seen", 32'(nwait), 32'd6);

        // r0 write discarded, unaligned store address passed through
        clear_mem();
        tie_high = 1'b1; wait_n = 0;
        put(0, i_type(6'h08, 5'd0, 5'd0, 16'd9));
        put(1, i_type(6'h2B, 5'd0, 5'd0, 16'h0083));
        put(2, 32'hFC00_0000);
        do_reset();
        run_until_halt(100);
        chk("r0_addr", wr_addr[0], 32'h83);
        chk("r0_data", wr_data[0], 32'd0);

        // Branch / jump: not-taken beq, j back to 0x100, then a self-loop beq at 0x10
        clear_mem();
        put(0, i_type(6'h08, 5'd0, 5'd1, 16'd1));
        put(1, i_type(6'h08, 5'd0, 5'd2, 16'd2));
        put(2, j_type(26'h4));
        mem[4] = i_type(6'h04, 5'd1, 5'd2, 16'd3);
        mem[5] = j_type(26'h40);
        do_reset();
        run_until_done(5, 200);
        mem[4] = i_type(6'h04, 5'd1, 5'd1, 16'hFFFF);
        run_until_done(9, 200);
        begin
            logic [31:0] exp_pc [9] = '{32'h104, 32'h108, 32'h10, 32'h14, 32'h100,
                                        32'h104, 32'h108, 32'h10, 32'h10};
            foreach (exp_pc[k]) chk($sformatf("br_pc%0d", k), done_pc[k], exp_pc[k]);
        end
        chk("addi_latency", 32'(done_cyc[1] - done_cyc[0]), 32'd4);
        chk("j_latency", 32'(done_cyc[2] - done_cyc[1]), 32'd3);
        chk("beq_latency", 32'(done_cyc[3] - done_cyc[2]), 32'd3);

        // Illegal opcode and illegal funct halt; reset recovers
        for (int h = 0; h < 2; h++) begin
            clear_mem();
            put(0, (h == 0) ? 32'hFC00_0000 : r_type(5'd1, 5'd2, 5'd3, 6'h07));
            do_reset();
            run_until_halt(50);
            halt_watch = 1;
            repeat (20) tick();
            halt_watch = 0;
            chk("halt_sticky", 32'(halted), 32'd1);
            chk("halt_no_retire", 32'(done_cyc.size()), 32'd0);
            rst = 1'b0;
            #1;
            chk("halt_cleared", 32'(halted), 32'd0);
            do_reset();
            tick();
            chk("restart_addr", mem_addr, 32'h100);
            chk("restart_req", 32'(mem_req), 32'd1);
        end

        // Reset while stalled in a load drops the request and clears registers
        clear_mem();
        tie_high = 1'b0; wait_n = 1000;
        put(0, i_type(6'h08, 5'd0, 5'd1, 16'h33));
        put(1, i_type(6'h08, 5'd0, 5'd4, 16'h55));
        put(2, i_type(6'h23, 5'd0, 5'd4, 16'h0008));
        do_reset();
        begin
            int n = 0;
            while (!(mem_req && mem_addr == 32'h8) && n < 50) begin
                tick();
                n++;
            end
        end
        repeat (2) tick();
        chk("stall_req", 32'(mem_req), 32'd1);
        chk("stall_addr", mem_addr, 32'h8);
        rst = 1'b0;
        #1;
        chk("rst_drops_req", 32'(mem_req), 32'd0);
        wait_n = 0;
        clear_mem();
        put(0, i_type(6'h2B, 5'd0, 5'd4, 16'h0020));
        put(1, i_type(6'h2B, 5'd0, 5'd1, 16'h0024));
        put(2, 32'hFC00_0000);
        do_reset();
        tick();
        chk("rst_restart_addr", mem_addr, 32'h100);
        run_until_halt(100);
        chk("rst_r4_addr", wr_addr[0], 32'h20);
        chk("rst_r4_zero", wr_data[0], 32'd0);
        chk("rst_r1_addr", wr_addr[1], 32'h24);
        chk("rst_r1_zero", wr_data[1], 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
